hazard_sequencer: RTL and testbench



---
 rtl/hazard_sequencer_pkg.sv | 42 ++++
 rtl/hazard_sequencer_hazard_detect.sv | 35 +++
 rtl/hazard_sequencer.sv | 148 ++++++++++++++
 tb/tb_hazard_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the five-stage pipeline sequencer: opcodes, NOP encoding,
// FSM state encoding and operand-usage decode helpers.
package hazard_sequencer_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_SLL  = 4'h4;
   localparam logic [3:0] OP_SRL  = 4'h5;
   localparam logic [3:0] OP_SRA  = 4'h6;
   localparam logic [3:0] OP_RL   = 4'h7;
   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'h9;
   localparam logic [3:0] OP_LHB  = 4'hA;
   localparam logic [3:0] OP_LLB  = 4'hB;
   localparam logic [3:0] OP_B    = 4'hC;
   localparam logic [3:0] OP_JAL  = 4'hD;
   localparam logic [3:0] OP_JR   = 4'hE;
   localparam logic [3:0] OP_EXEC = 4'hF;

   localparam logic [15:0] NOP_INSTR = 16'h0000;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   function automatic logic reads_rs(input logic [3:0] op);
      return (op <= OP_SW);
   endfunction

   function automatic logic reads_rt(input logic [3:0] op);
      return (op <= OP_OR);
   endfunction

   // SW stores Rd, LHB merges into Rd, JR/EXEC use Rd as the target address.
   function automatic logic reads_rd(input logic [3:0] op);
      return (op == OP_SW) || (op == OP_LHB) || (op == OP_JR) || (op == OP_EXEC);
   endfunction

endpackage

// File: rtl/hazard_sequencer_hazard_detect.sv
// Combinational load-use detector: flags when the instruction in EX is a load whose
// destination is a register the decode-stage instruction reads.
module hazard_detect
   import hazard_sequencer_pkg::*;
#(
   parameter int ISIZE = 16,
   parameter int RSIZE = 4
) (
   input  logic [ISIZE-1:0] id_instr,
   input  logic [3:0]       ex_op,
   input  logic [RSIZE-1:0] ex_rd,
   output logic             load_use
);

   logic [3:0]       w_op;
   logic [RSIZE-1:0] w_rs;
   logic [RSIZE-1:0] w_rt;
   logic [RSIZE-1:0] w_rd;
   logic             w_hit_rs;
   logic             w_hit_rt;
   logic             w_hit_rd;

   assign w_op = id_instr[ISIZE-1:ISIZE-4];
   assign w_rd = id_instr[3*RSIZE-1:2*RSIZE];
   assign w_rs = id_instr[2*RSIZE-1:RSIZE];
   assign w_rt = id_instr[RSIZE-1:0];

   assign w_hit_rs = reads_rs(w_op) && (w_rs == ex_rd);
   assign w_hit_rt = reads_rt(w_op) && (w_rt == ex_rd);
   assign w_hit_rd = reads_rd(w_op) && (w_rd == ex_rd);

   // R0 is hardwired zero, so a load into it never creates a dependency.
   assign load_use = (ex_op == OP_LW) && (ex_rd != '0) && (w_hit_rs || w_hit_rt || w_hit_rd);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: owns pipeline-register enables and flushes, handles
// load-use bubbles, taken-branch squashes and data-memory wait with timeout.
module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int ISIZE       = 16,
   parameter int RSIZE       = 4,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ISIZE-1:0] id_instr,
   input  logic             ex_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             idex_we,
   output logic             exmem_we,
   output logic             memwb_we,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             mem_err
);

   localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCNT_W-1:0] TIMEOUT_VAL = WCNT_W'(MEM_TIMEOUT);

   state_t           r_state;
   state_t           w_state_next;
   logic [WCNT_W-1:0] r_wait_cnt;
   logic [WCNT_W-1:0] w_wait_next;
   logic [3:0]       r_ex_op;
   logic [RSIZE-1:0] r_ex_rd;
   logic [CNT_W-1:0] r_stall_cycles;
   logic             r_mem_err;
   logic             w_freeze;
   logic             w_load_use;

   assign w_freeze = mem_req & ~mem_ready;

   hazard_detect #(
      .ISIZE (ISIZE),
      .RSIZE (RSIZE)
   ) u_hazard_detect (
      .id_instr (id_instr),
      .ex_op    (r_ex_op),
      .ex_rd    (r_ex_rd),
      .load_use (w_load_use)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN:  if (w_freeze)  w_state_next = ST_WAIT;
         ST_WAIT: if (!w_freeze) w_state_next = ST_RUN;
         default: w_state_next = ST_RUN;
      endcase
   end

   always_comb begin
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      idex_we    = 1'b1;
      exmem_we   = 1'b1;
      memwb_we   = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (w_freeze) begin
         pc_we    = 1'b0;
         ifid_we  = 1'b0;
         idex_we  = 1'b0;
         exmem_we = 1'b0;
         memwb_we = 1'b0;
      end else if (ex_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (w_load_use) begin
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   // Counter value for the current freeze cycle: 1 on entry, saturating at the timeout.
   always_comb begin
      w_wait_next = '0;
      if (w_freeze) begin
         if (r_state == ST_RUN) begin
            w_wait_next = WCNT_W'(1);
         end else if (r_wait_cnt == TIMEOUT_VAL) begin
            w_wait_next = r_wait_cnt;
         end else begin
            w_wait_next = r_wait_cnt + WCNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         r_wait_cnt <= w_wait_next;
         if (w_freeze && (w_wait_next == TIMEOUT_VAL)) begin
            r_mem_err <= 1'b1;
         end
      end
   end

   // Only opcode and Rd of the EX instruction matter for hazard detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_op <= NOP_INSTR[15:12];
         r_ex_rd <= '0;
      end else if (idex_we) begin
         if (idex_flush) begin
            r_ex_op <= NOP_INSTR[15:12];
            r_ex_rd <= '0;
         end else begin
            r_ex_op <= id_instr[ISIZE-1:ISIZE-4];
            r_ex_rd <= id_instr[3*RSIZE-1:2*RSIZE];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
      end else if (!pc_we && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign mem_err      = r_mem_err;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer with hand-computed control vectors.
module tb_hazard_sequencer;

   logic        clk;
   logic        rst_n;
   logic [15:0] id_instr;
   logic        ex_taken;
   logic        mem_req;
   logic        mem_ready;
   logic        pc_we;
   logic        ifid_we;
   logic        idex_we;
   logic        exmem_we;
   logic        memwb_we;
   logic        ifid_flush;
   logic        idex_flush;
   logic [15:0] stall_cycles;
   logic        mem_err;

   int n_checks = 0;
   int n_pass   = 0;

   // {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush}
   localparam logic [6:0] CTL_NORM  = 7'b1111100;
   localparam logic [6:0] CTL_LU    = 7'b0011101;
   localparam logic [6:0] CTL_TAKEN = 7'b1111111;
   localparam logic [6:0] CTL_FRZ   = 7'b0000000;

   hazard_sequencer #(
      .ISIZE       (16),
      .RSIZE       (4),
      .MEM_TIMEOUT (4),
      .CNT_W       (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_instr     (id_instr),
      .ex_taken     (ex_taken),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .pc_we        (pc_we),
      .ifid_we      (ifid_we),
      .idex_we      (idex_we),
      .exmem_we     (exmem_we),
      .memwb_we     (memwb_we),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .stall_cycles (stall_cycles),
      .mem_err      (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, check the control vector mid-cycle, then clock it.
   task automatic cyc(input string tag, input logic [15:0] id, input logic tk,
                      input logic rq, input logic rdy, input logic [6:0] exp_ctl,
                      input logic [15:0] exp_sc, input logic exp_err);
      id_instr  = id;
      ex_taken  = tk;
      mem_req   = rq;
      mem_ready = rdy;
      #2;
      $display("cyc %-10s id=%h tk=%0b rq=%0b rdy=%0b ctl=%b sc=%0d err=%0b",
               tag, id, tk, rq, rdy,
               {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush},
               stall_cycles, mem_err);
      check_eq({tag, ".ctl"},
               {25'd0, pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush},
               {25'd0, exp_ctl});
      check_eq({tag, ".sc"}, {16'd0, stall_cycles}, {16'd0, exp_sc});
      check_eq({tag, ".err"}, {31'd0, mem_err}, {31'd0, exp_err});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      id_instr  = 16'h0000;
      ex_taken  = 1'b0;
      mem_req   = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      cyc("reset",    16'h0000, 0, 0, 0, CTL_NORM, 16'd0, 0);
      // Load-use through Rs, then one bubble only.
      cyc("lw_r3",    16'h8310, 0, 0, 0, CTL_NORM, 16'd0, 0);
      cyc("lu_rs",    16'h0432, 0, 0, 0, CTL_LU,   16'd0, 0);
      cyc("lu_after", 16'h0432, 0, 0, 0, CTL_NORM, 16'd1, 0);
      // LW into R0 never stalls.
      cyc("lw_r0",    16'h8010, 0, 0, 0, CTL_NORM, 16'd1, 0);
      cyc("r0_use",   16'h0402, 0, 0, 0, CTL_NORM, 16'd1, 0);
      // SW reads Rd.
      cyc("lw_r5",    16'h8510, 0, 0, 0, CTL_NORM, 16'd1, 0);
      cyc("lu_sw_rd", 16'h9510, 0, 0, 0, CTL_LU,   16'd1, 0);
      cyc("sw_after", 16'h9510, 0, 0, 0, CTL_NORM, 16'd2, 0);
      // SLL does not read Rt: no hazard on Rt match.
      cyc("lw_r3b",   16'h8310, 0, 0, 0, CTL_NORM, 16'd2, 0);
      cyc("sll_rt",   16'h4213, 0, 0, 0, CTL_NORM, 16'd2, 0);
      // ADD reads Rt.
      cyc("lw_r3c",   16'h8310, 0, 0, 0, CTL_NORM, 16'd2, 0);
      cyc("lu_rt",    16'h0423, 0, 0, 0, CTL_LU,   16'd2, 0);
      cyc("rt_after", 16'h0423, 0, 0, 0, CTL_NORM, 16'd3, 0);
      // Taken branch overrides a simultaneous load-use.
      cyc("lw_r3d",   16'h8310, 0, 0, 0, CTL_NORM, 16'd3, 0);
      cyc("taken_lu", 16'h0432, 1, 0, 0, CTL_TAKEN, 16'd3, 0);
      cyc("tk_after", 16'h0432, 0, 0, 0, CTL_NORM, 16'd3, 0);
      // Three-cycle memory wait.
      cyc("mw1",      16'h0432, 0, 1, 0, CTL_FRZ,  16'd3, 0);
      cyc("mw2",      16'h0432, 0, 1, 0, CTL_FRZ,  16'd4, 0);
      cyc("mw3",      16'h0432, 0, 1, 0, CTL_FRZ,  16'd5, 0);
      cyc("mw_done",  16'h0432, 0, 1, 1, CTL_NORM, 16'd6, 0);
      cyc("mw_idle",  16'h0000, 0, 0, 0, CTL_NORM, 16'd6, 0);
      // Six-cycle wait with timeout of four.
      cyc("to1",      16'h0000, 0, 1, 0, CTL_FRZ,  16'd6, 0);
      cyc("to2",      16'h0000, 0, 1, 0, CTL_FRZ,  16'd7, 0);
      cyc("to3",      16'h0000, 0, 1, 0, CTL_FRZ,  16'd8, 0);
      cyc("to4",      16'h0000, 0, 1, 0, CTL_FRZ,  16'd9, 0);
      cyc("to5",      16'h0000, 0, 1, 0, CTL_FRZ,  16'd10, 1);
      cyc("to6",      16'h0000, 0, 1, 0, CTL_FRZ,  16'd11, 1);
      cyc("to_done",  16'h0000, 0, 1, 1, CTL_NORM, 16'd12, 1);
      cyc("to_idle",  16'h0000, 0, 0, 0, CTL_NORM, 16'd12, 1);
      // Reset during the second wait cycle with a load in the EX shadow.
      cyc("rw_lw",    16'h8310, 0, 0, 0, CTL_NORM, 16'd12, 1);
      cyc("rw1",      16'h0432, 0, 1, 0, CTL_FRZ,  16'd12, 1);
      id_instr = 16'h0432;
      #2;
      check_eq("rw2.ctl",
               {25'd0, pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush},
               {25'd0, CTL_FRZ});
      rst_n   = 1'b0;
      mem_req = 1'b0;
      #1;
      $display("rst mid-wait ctl=%b sc=%0d err=%0b",
               {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush},
               stall_cycles, mem_err);
      check_eq("rst.sc",  {16'd0, stall_cycles}, 32'd0);
      check_eq("rst.err", {31'd0, mem_err}, 32'd0);
      check_eq("rst.ctl",
               {25'd0, pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush},
               {25'd0, CTL_NORM});
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // Shadow is NOP: the dependent ADD must not stall.
      cyc("post_rst", 16'h0432, 0, 0, 0, CTL_NORM, 16'd0, 0);
      cyc("post_rs2", 16'h0000, 0, 0, 0, CTL_NORM, 16'd0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
